pwm_capture: RTL and testbench

Receive-side counterpart of the PWM generator: samples a single-bit PWM waveform and measures high time and period in clock cycles for every complete period. Reports each measurement with a one-cycle strobe, plus a 3-bit duty code that recovers the generator's switch setting. Flags a stuck line when no edge arrives within the timeout window. Sits at the PWM input pin, downstream of the generator in loopback benches and board tests.

---
 rtl/pwm_pkg.sv | 23 ++
 rtl/pwm_sync.sv | 31 +++
 rtl/pwm_capture.sv | 162 ++++++++++++++++
 tb/tb_pwm_capture.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture path: default counter width,
// FSM state encoding and the duty-code mapping.
package pwm_pkg;

   localparam int CBITS_DEFAULT = 14;

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW
   } state_t;

   // Top three bits below the half-scale bit; anything at or above half scale reads as 7.
   function automatic logic [2:0] duty_code_of(input logic [31:0] w, input int cbits);
      logic [31:0] half;
      half = 32'd1 << (cbits - 1);
      if (w >= half) begin
         return 3'd7;
      end
      return 3'(w >> (cbits - 4));
   endfunction

endpackage

// File: rtl/pwm_sync.sv
// Two-flop synchronizer for the PWM input plus a delayed copy for edge detection.
module pwm_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic pulse_in,
   output logic pulse_s,
   output logic rise,
   output logic fall
);

   logic sync1_reg;
   logic pulse_s_reg;
   logic pulse_d_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_reg   <= 1'b0;
         pulse_s_reg <= 1'b0;
         pulse_d_reg <= 1'b0;
      end else begin
         sync1_reg   <= pulse_in;
         pulse_s_reg <= sync1_reg;
         pulse_d_reg <= pulse_s_reg;
      end
   end

   assign pulse_s = pulse_s_reg;
   assign rise    = pulse_s_reg & ~pulse_d_reg;
   assign fall    = ~pulse_s_reg & pulse_d_reg;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of every complete PWM period and flags a
// stuck line when no edge arrives within the timeout window.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int CBITS = CBITS_DEFAULT
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           pulse_in,
   output logic [CBITS:0] width,
   output logic [CBITS:0] period,
   output logic [2:0]     duty_code,
   output logic           valid,
   output logic           stuck
);

   localparam logic [CBITS:0] CNT_MAX = '1;
   localparam logic [CBITS:0] CNT_ONE = {{CBITS{1'b0}}, 1'b1};

   logic pulse_s;
   logic rise;
   logic fall;

   pwm_sync u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .pulse_in (pulse_in),
      .pulse_s  (pulse_s),
      .rise     (rise),
      .fall     (fall)
   );

   state_t         state_reg, state_next;
   logic [CBITS:0] hi_cnt_reg, hi_cnt_next;
   logic [CBITS:0] per_cnt_reg, per_cnt_next;
   logic [CBITS:0] gap_cnt_reg, gap_cnt_next;

   // Report stage between the FSM and the output registers.
   logic           rep_valid_reg, rep_valid_next;
   logic [CBITS:0] rep_width_reg, rep_width_next;
   logic [CBITS:0] rep_period_reg, rep_period_next;
   logic           rep_stuck_reg, rep_stuck_next;

   logic [CBITS:0] width_reg;
   logic [CBITS:0] period_reg;
   logic [2:0]     duty_reg;
   logic           valid_reg;
   logic           stuck_reg;

   function automatic logic [CBITS:0] sat_inc(input logic [CBITS:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         hi_cnt_reg     <= '0;
         per_cnt_reg    <= '0;
         gap_cnt_reg    <= '0;
         rep_valid_reg  <= 1'b0;
         rep_width_reg  <= '0;
         rep_period_reg <= '0;
         rep_stuck_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         hi_cnt_reg     <= hi_cnt_next;
         per_cnt_reg    <= per_cnt_next;
         gap_cnt_reg    <= gap_cnt_next;
         rep_valid_reg  <= rep_valid_next;
         rep_width_reg  <= rep_width_next;
         rep_period_reg <= rep_period_next;
         rep_stuck_reg  <= rep_stuck_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      hi_cnt_next     = hi_cnt_reg;
      per_cnt_next    = per_cnt_reg;
      gap_cnt_next    = gap_cnt_reg;
      rep_valid_next  = 1'b0;
      rep_width_next  = '0;
      rep_period_next = '0;
      rep_stuck_next  = 1'b0;

      case (state_reg)
         IDLE: begin
            if (rise) begin
               hi_cnt_next  = CNT_ONE;
               per_cnt_next = CNT_ONE;
               gap_cnt_next = '0;
               state_next   = HIGH;
            end
         end
         HIGH: begin
            if (fall) begin
               per_cnt_next = sat_inc(per_cnt_reg);
               gap_cnt_next = '0;
               state_next   = LOW;
            end else if (gap_cnt_reg == CNT_MAX) begin
               // Line stuck at its current level: high reads full scale, low reads zero.
               rep_valid_next = 1'b1;
               rep_width_next = pulse_s ? CNT_MAX : '0;
               rep_stuck_next = 1'b1;
               state_next     = IDLE;
            end else begin
               hi_cnt_next  = sat_inc(hi_cnt_reg);
               per_cnt_next = sat_inc(per_cnt_reg);
               gap_cnt_next = sat_inc(gap_cnt_reg);
            end
         end
         LOW: begin
            if (rise) begin
               rep_valid_next  = 1'b1;
               rep_width_next  = hi_cnt_reg;
               rep_period_next = per_cnt_reg;
               hi_cnt_next     = CNT_ONE;
               per_cnt_next    = CNT_ONE;
               gap_cnt_next    = '0;
               state_next      = HIGH;
            end else if (gap_cnt_reg == CNT_MAX) begin
               rep_valid_next = 1'b1;
               rep_width_next = pulse_s ? CNT_MAX : '0;
               rep_stuck_next = 1'b1;
               state_next     = IDLE;
            end else begin
               per_cnt_next = sat_inc(per_cnt_reg);
               gap_cnt_next = sat_inc(gap_cnt_reg);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_reg  <= 1'b0;
         width_reg  <= '0;
         period_reg <= '0;
         duty_reg   <= 3'd0;
         stuck_reg  <= 1'b0;
      end else begin
         valid_reg <= rep_valid_reg;
         if (rep_valid_reg) begin
            width_reg  <= rep_width_reg;
            period_reg <= rep_period_reg;
            duty_reg   <= duty_code_of(32'(rep_width_reg), CBITS);
            stuck_reg  <= rep_stuck_reg;
         end
      end
   end

   assign width     = width_reg;
   assign period    = period_reg;
   assign duty_code = duty_reg;
   assign valid     = valid_reg;
   assign stuck     = stuck_reg;

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized and directed PWM waveforms checked against an edge-timestamp
// model: each report follows from the sampled rise/fall times of pulse_in.
module tb_pwm_capture;

   localparam int CB   = 6;
   localparam int MAXV = 2 ** (CB + 1) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          pulse_in = 1'b0;
   logic [CB:0]   width;
   logic [CB:0]   period;
   logic [2:0]    duty_code;
   logic          valid;
   logic          stuck;

   pwm_capture #(.CBITS(CB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pulse_in  (pulse_in),
      .width     (width),
      .period    (period),
      .duty_code (duty_code),
      .valid     (valid),
      .stuck     (stuck)
   );

   always #5 clk = ~clk;

   typedef struct {
      int t;
      int w;
      int p;
      bit s;
   } rep_t;

   rep_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   bit   armed = 0;
   logic prev = 1'b0;
   int   last_rise = 0;
   int   last_fall = 0;
   int   last_edge = 0;
   int   exp_w = 0;
   int   exp_p = 0;
   bit   exp_s = 0;
   int   n_reports = 0;

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int duty_of(input int w);
      if (w >= 2 ** (CB - 1)) return 7;
      return w / (2 ** (CB - 4));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   // Reference: a rise sampled at cycle c reports at c+3 using the previous
   // rise/fall timestamps; silence for MAXV+2 samples after an edge times out.
   task automatic model_sample(input logic lvl);
      rep_t r;
      if (armed && cyc == last_edge + MAXV + 2) begin
         r.t = cyc + 2; r.w = prev ? MAXV : 0; r.p = 0; r.s = 1'b1;
         q.push_back(r);
         armed = 0;
      end
      if (lvl !== prev) begin
         if (lvl) begin
            if (armed) begin
               r.t = cyc + 3;
               r.w = imin(last_fall - last_rise, MAXV);
               r.p = imin(cyc - last_rise, MAXV);
               r.s = 1'b0;
               q.push_back(r);
            end
            armed = 1;
            last_rise = cyc;
         end else begin
            last_fall = cyc;
         end
         last_edge = cyc;
      end
      prev = lvl;
   endtask

   task automatic check_outputs();
      bit exp_v;
      exp_v = 0;
      if (q.size() > 0 && q[0].t == cyc) begin
         exp_v = 1;
         exp_w = q[0].w;
         exp_p = q[0].p;
         exp_s = q[0].s;
         void'(q.pop_front());
         n_reports++;
      end
      chk("valid", 32'(valid), 32'(exp_v));
      chk("width", 32'(width), exp_w);
      chk("period", 32'(period), exp_p);
      chk("duty_code", 32'(duty_code), duty_of(exp_w));
      chk("stuck", 32'(stuck), 32'(exp_s));
      if (exp_v)
         $display("[TB] cycle %0d report width=%0d period=%0d duty=%0d stuck=%0d",
                  cyc, width, period, duty_code, stuck);
   endtask

   task automatic step(input logic lvl);
      pulse_in = lvl;
      @(posedge clk);
      cyc++;
      model_sample(lvl);
      #1;
      check_outputs();
   endtask

   task automatic phase(input logic lvl, input int n);
      for (int i = 0; i < n; i++) step(lvl);
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         cyc++;
         #1;
         chk("rst_valid", 32'(valid), 0);
         chk("rst_width", 32'(width), 0);
         chk("rst_period", 32'(period), 0);
         chk("rst_duty", 32'(duty_code), 0);
         chk("rst_stuck", 32'(stuck), 0);
      end
      q.delete();
      armed = 0;
      prev = 1'b0;
      exp_w = 0;
      exp_p = 0;
      exp_s = 0;
      rst_n = 1'b1;
   endtask

   task automatic random_phases(input int n);
      int len;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 9) == 0) len = $urandom_range(100, 180);
         else len = $urandom_range(2, 40);
         phase(i[0] ? 1'b0 : 1'b1, len);
      end
   endtask

   initial begin
      do_reset(3);

      // Constant low after reset: silent idle.
      phase(1'b0, 40);

      // 3 high / 5 low: width 3, period 8, duty 0.
      for (int i = 0; i < 8; i++) begin
         phase(1'b1, 3);
         phase(1'b0, 5);
      end

      // Timeout boundaries: 128-cycle phase still measures, 129 times out.
      phase(1'b1, 10); phase(1'b0, 128);
      phase(1'b1, 10); phase(1'b0, 129);
      phase(1'b1, 20); phase(1'b0, 20);
      phase(1'b1, 128); phase(1'b0, 10);
      phase(1'b1, 129); phase(1'b0, 10);
      phase(1'b1, 12); phase(1'b0, 12);
      phase(1'b1, 12); phase(1'b0, 12);

      random_phases(150);

      // Reset in the middle of a high phase; the line stays high through it.
      phase(1'b1, 10);
      do_reset(2);
      phase(1'b1, 7); phase(1'b0, 9);
      phase(1'b1, 4); phase(1'b0, 6);
      phase(1'b1, 5);

      random_phases(50);
      phase(1'b0, 200);
      phase(1'b1, 200);
      phase(1'b0, 10);

      chk("reports_drained", 32'(q.size()), 0);
      chk("reports_seen_min", 32'(n_reports > 100), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
